// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline stage boundary.
// The slave modport is the stage register's view; master is the driving side.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 3,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned TAG_W  = 25
);
    logic                    stall_i;
    logic                    flush_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [LANES*DATA_W-1:0] data_i;
    logic [CTRL_W-1:0]       ctrl_i;
    logic [TAG_W-1:0]        tag_i;
    logic                    valid_o;
    logic                    ready_i;
    logic [LANES*DATA_W-1:0] data_o;
    logic [CTRL_W-1:0]       ctrl_o;
    logic [TAG_W-1:0]        tag_o;
    logic [1:0]              occ_o;

    modport slave (
        input  stall_i, flush_i, valid_i, data_i, ctrl_i, tag_i, ready_i,
        output ready_o, valid_o, data_o, ctrl_o, tag_o, occ_o
    );

    modport master (
        output stall_i, flush_i, valid_i, data_i, ctrl_i, tag_i, ready_i,
        input  ready_o, valid_o, data_o, ctrl_o, tag_o, occ_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry and make ready_o registered.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 3,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned TAG_W  = 25
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_stage_reg_if.slave     bus
);
    localparam int unsigned DW = LANES * DATA_W;

    logic              r_main_valid;
    logic [DW-1:0]     r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [TAG_W-1:0]  r_main_tag;
    logic              w_main_valid_nxt;
    logic [DW-1:0]     w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [TAG_W-1:0]  w_main_tag_nxt;

    logic w_ready;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_out_xfer = r_main_valid & bus.ready_i & ~bus.stall_i;
    assign w_in_xfer  = bus.valid_i & w_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              r_skid_valid;
    logic [DW-1:0]     r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              w_skid_valid_nxt;
    logic [DW-1:0]     w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [TAG_W-1:0]  w_skid_tag_nxt;

    // Ready looks only at the skid slot, so ready_i never reaches ready_o.
    assign w_ready   = ~r_skid_valid & ~bus.stall_i & ~bus.flush_i & ~rst_i;
    assign bus.occ_o = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_main_tag_nxt   = r_main_tag;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_tag_nxt   = r_skid_tag;
        if (bus.flush_i) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!bus.stall_i) begin
            if (w_out_xfer) begin
                if (r_skid_valid) begin
                    w_main_data_nxt  = r_skid_data;
                    w_main_ctrl_nxt  = r_skid_ctrl;
                    w_main_tag_nxt   = r_skid_tag;
                    w_skid_valid_nxt = 1'b0;
                end else if (w_in_xfer) begin
                    w_main_data_nxt  = bus.data_i;
                    w_main_ctrl_nxt  = bus.ctrl_i;
                    w_main_tag_nxt   = bus.tag_i;
                end else begin
                    w_main_valid_nxt = 1'b0;
                end
            end else if (w_in_xfer) begin
                if (!r_main_valid) begin
                    w_main_valid_nxt = 1'b1;
                    w_main_data_nxt  = bus.data_i;
                    w_main_ctrl_nxt  = bus.ctrl_i;
                    w_main_tag_nxt   = bus.tag_i;
                end else begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = bus.data_i;
                    w_skid_ctrl_nxt  = bus.ctrl_i;
                    w_skid_tag_nxt   = bus.tag_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_skid_tag   <= '0;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_tag   <= w_skid_tag_nxt;
        end
    end
`else
    // Single entry: accept when empty or when the held beat leaves this cycle.
    assign w_ready   = (~r_main_valid | bus.ready_i) & ~bus.stall_i & ~bus.flush_i & ~rst_i;
    assign bus.occ_o = {1'b0, r_main_valid};

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_main_ctrl_nxt  = r_main_ctrl;
        w_main_tag_nxt   = r_main_tag;
        if (bus.flush_i) begin
            w_main_valid_nxt = 1'b0;
        end else if (!bus.stall_i) begin
            if (w_in_xfer) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = bus.data_i;
                w_main_ctrl_nxt  = bus.ctrl_i;
                w_main_tag_nxt   = bus.tag_i;
            end else if (w_out_xfer) begin
                w_main_valid_nxt = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_main_tag   <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_main_ctrl  <= w_main_ctrl_nxt;
            r_main_tag   <= w_main_tag_nxt;
        end
    end

    // A bubble must never present RegWrite or MemWrite downstream.
    assign bus.ctrl_o  = r_main_valid ? r_main_ctrl : '0;
    assign bus.ready_o = w_ready;
    assign bus.valid_o = r_main_valid;
    assign bus.data_o  = r_main_data;
    assign bus.tag_o   = r_main_tag;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg; expectations follow PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 3;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned TAG_W  = 25;

    typedef struct packed {
        logic        rs, st, fl, vi, ri;
        logic [31:0] d;
        logic [6:0]  c;
        logic        er, ev;
        logic [31:0] ed;
        logic [6:0]  ec;
        logic [1:0]  eo;
    } vec_t;

    logic clk_i;
    logic rst_i;
    int   n_cmp;
    int   n_err;
    vec_t tbl[21];

    pipe_stage_reg_if #(
        .DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .TAG_W(TAG_W)
    ) bus ();

    pipe_stage_reg #(
        .DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [95:0] lanes(input logic [31:0] x);
        return {x << 2, x << 1, x};
    endfunction

    function automatic logic [24:0] tagf(input logic [31:0] x);
        return 25'(x * 32'd5);
    endfunction

    function automatic vec_t mk(input logic rs, st, fl, vi, ri, input logic [31:0] d,
                                input logic [6:0] c, input logic er, ev,
                                input logic [31:0] ed, input logic [6:0] ec,
                                input logic [1:0] eo);
        vec_t v;
        v.rs = rs; v.st = st; v.fl = fl; v.vi = vi; v.ri = ri; v.d = d; v.c = c;
        v.er = er; v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: ready_o is sampled before the edge, registered outputs after it.
    task automatic step(input string name, input vec_t v);
        rst_i       = v.rs;
        bus.stall_i = v.st;
        bus.flush_i = v.fl;
        bus.valid_i = v.vi;
        bus.ready_i = v.ri;
        bus.data_i  = lanes(v.d);
        bus.ctrl_i  = v.c;
        bus.tag_i   = tagf(v.d);
        #1;
        chk({name, " ready_o"}, 128'(bus.ready_o), 128'(v.er));
        @(posedge clk_i);
        #1;
        chk({name, " valid_o"}, 128'(bus.valid_o), 128'(v.ev));
        chk({name, " data_o"},  128'(bus.data_o),  128'(lanes(v.ed)));
        chk({name, " tag_o"},   128'(bus.tag_o),   128'(tagf(v.ed)));
        chk({name, " ctrl_o"},  128'(bus.ctrl_o),  128'(v.ec));
        chk({name, " occ_o"},   128'(bus.occ_o),   128'(v.eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        // Reset held two cycles with a beat offered, then release.
        tbl[0] = mk(1, 0, 0, 1, 1, 32'hFFFF_FFFF, 7'h7F, 0, 0, 0, 7'h00, 0);
        tbl[1] = mk(1, 0, 0, 1, 1, 32'hFFFF_FFFF, 7'h7F, 0, 0, 0, 7'h00, 0);
        tbl[2] = mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 0, 7'h00, 0);
        // Streaming 1..8, each beat visible one edge after its accept.
        for (int k = 1; k <= 8; k++)
            tbl[2+k] = mk(0, 0, 0, 1, 1, 32'(k), 7'(8'h40 + k), 1, 1, 32'(k),
                          7'(8'h40 + k), 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 8, 7'h00, 0);
        // Stall for three cycles over a held beat with all control bits set.
        tbl[12] = mk(0, 0, 0, 1, 0, 9, 7'h7F, 1, 1, 9, 7'h7F, 1);
        tbl[13] = mk(0, 1, 0, 1, 1, 10, 7'h01, 0, 1, 9, 7'h7F, 1);
        tbl[14] = mk(0, 1, 0, 1, 1, 10, 7'h01, 0, 1, 9, 7'h7F, 1);
        tbl[15] = mk(0, 1, 0, 1, 1, 10, 7'h01, 0, 1, 9, 7'h7F, 1);
        tbl[16] = mk(0, 0, 0, 1, 1, 10, 7'h0A, 1, 1, 10, 7'h0A, 1);
        // Flush beats stall; data/tag are kept while ctrl_o goes to zero.
        tbl[17] = mk(0, 1, 1, 1, 1, 11, 7'h0B, 0, 0, 10, 7'h00, 0);
        tbl[18] = mk(0, 0, 0, 1, 1, 12, 7'h0C, 1, 1, 12, 7'h0C, 1);
        // Reset beats flush and stall together.
        tbl[19] = mk(1, 1, 1, 1, 1, 13, 7'h0D, 0, 0, 0, 7'h00, 0);
        tbl[20] = mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 0, 7'h00, 0);

        for (int i = 0; i < 21; i++) step($sformatf("tbl[%0d]", i), tbl[i]);

`ifdef PIPE_STAGE_REG_SKID_EN
        step("bp0", mk(0, 0, 0, 1, 1, 21, 7'h15, 1, 1, 21, 7'h15, 1));
        step("bp1", mk(0, 0, 0, 1, 0, 22, 7'h16, 1, 1, 21, 7'h15, 2));
        step("bp2", mk(0, 0, 0, 1, 0, 23, 7'h17, 0, 1, 21, 7'h15, 2));
        step("bp3", mk(0, 0, 0, 1, 1, 23, 7'h17, 0, 1, 22, 7'h16, 1));
        step("bp4", mk(0, 0, 0, 1, 1, 23, 7'h17, 1, 1, 23, 7'h17, 1));
        step("bp5", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 23, 7'h00, 0));
        step("fl0", mk(0, 0, 0, 1, 1, 31, 7'h1F, 1, 1, 31, 7'h1F, 1));
        step("fl1", mk(0, 0, 0, 1, 0, 32, 7'h20, 1, 1, 31, 7'h1F, 2));
        step("fl2", mk(0, 0, 1, 1, 0, 33, 7'h21, 0, 0, 31, 7'h00, 0));
        step("fl3", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 31, 7'h00, 0));
        step("fl4", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 31, 7'h00, 0));
        step("rs0", mk(0, 0, 0, 1, 1, 41, 7'h29, 1, 1, 41, 7'h29, 1));
        step("rs1", mk(0, 0, 0, 1, 0, 42, 7'h2A, 1, 1, 41, 7'h29, 2));
        step("rs2", mk(1, 0, 0, 1, 1, 43, 7'h2B, 0, 0, 0, 7'h00, 0));
        step("rs3", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 0, 7'h00, 0));
`else
        step("bp0", mk(0, 0, 0, 1, 1, 21, 7'h15, 1, 1, 21, 7'h15, 1));
        step("bp1", mk(0, 0, 0, 1, 0, 22, 7'h16, 0, 1, 21, 7'h15, 1));
        step("bp2", mk(0, 0, 0, 1, 1, 22, 7'h16, 1, 1, 22, 7'h16, 1));
        step("bp3", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 22, 7'h00, 0));
        step("fl0", mk(0, 0, 0, 1, 1, 31, 7'h1F, 1, 1, 31, 7'h1F, 1));
        step("fl1", mk(0, 0, 1, 1, 0, 33, 7'h21, 0, 0, 31, 7'h00, 0));
        step("fl2", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 31, 7'h00, 0));
        step("rs0", mk(0, 0, 0, 1, 1, 41, 7'h29, 1, 1, 41, 7'h29, 1));
        step("rs1", mk(1, 0, 0, 1, 1, 43, 7'h2B, 0, 0, 0, 7'h00, 0));
        step("rs2", mk(0, 0, 0, 0, 1, 0, 7'h00, 1, 0, 0, 7'h00, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-field ID/EX latch. It carries LANES data words, a control bundle and an address/funct tag between two pipeline stages. Transfers use a valid/ready handshake in both directions, with stall and flush (bubble insertion) controls on top. An optional skid entry gives full throughput with a registered ready. One instance sits at each stage boundary, IF/ID through MEM/WB.

## Interface
- DATA_W, 32, width of one data lane
- LANES, 3, number of data lanes; for ID/EX these are RS1 data, RS2 data and sign-extended immediate
- CTRL_W, 7, control bundle width (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc)
- TAG_W, 25, tag width (funct[9:0], RdAddr, RS1Addr, RS2Addr)
- clk_i  in  1  the single clock; all state changes on its rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  freeze the stage
- flush_i  in  1  discard all held beats and insert a bubble
- valid_i  in  1  upstream beat valid
- ready_o  out  1  stage can accept a beat
- data_i  in  LANES*DATA_W  lane 0 in the LSBs
- ctrl_i  in  CTRL_W  control bundle
- tag_i  in  TAG_W  register addresses and funct
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- data_o  out  LANES*DATA_W  output lanes
- ctrl_o  out  CTRL_W  output control, gated by valid_o
- tag_o  out  TAG_W  output tag
- occ_o  out  2  number of beats held (0..2)

## Operation
- Input transfer: valid_i & ready_o at a rising edge. Output transfer: valid_o & ready_i & !stall_i at a rising edge.
- Storage:
  - Main entry drives data_o and tag_o.
  - Skid entry exists only when SKID is enabled (see Configuration).
- ctrl_o = valid_o ? main.ctrl : 0. A bubble never presents RegWrite or MemWrite.
- Priority at each edge: rst_i > flush_i > stall_i > normal handshake.
- rst_i:
  - All valids, data, ctrl and tag registers clear to 0, so valid_o=0, data_o=0, ctrl_o=0, tag_o=0, occ_o=0.
  - ready_o=0 while rst_i=1.
- flush_i:
  - Main and skid valids clear at the edge; occ_o becomes 0.
  - A beat offered in the same cycle is dropped.
  - Data and tag registers keep their values; ctrl_o reads 0 because of the valid gating.
  - ready_o=0 during the flush cycle.
- stall_i:
  - No register changes.
  - ready_o=0.
  - valid_o, data_o, ctrl_o and tag_o are held.
  - No downstream transfer occurs even if ready_i=1.
- Normal operation:
  - Main empty, or main leaving: an accepted beat loads main.
  - Main full and not leaving: an accepted beat loads skid.
  - Main leaving with skid full: skid moves to main and skid empties.
- occ_o = main.valid + skid.valid.

## Timing
- Latency: an accepted beat appears on valid_o at the next edge (1 cycle) when the stage is empty or draining.
- Throughput: 1 beat/cycle while ready_i=1.
- With skid, ready_o = !skid.valid & !stall_i & !flush_i & !rst_i. ready_o depends only on registers plus the three control inputs, with no path from ready_i.
- With skid, back-pressure reaches upstream 1 cycle late: the beat accepted in the first cycle of ready_i=0 goes to skid, and ready_o falls at the next edge.
- Skid recovery: skid is drained into main on the first output transfer, and ready_o rises at that same edge.
- Boundary cases:
  - Simultaneous input and output transfer with occ_o=1: occ_o stays 1 and main is replaced.
  - With occ_o=2, ready_o=0, so no input transfer is possible.
  - Reset or flush asserted while occ_o=2: both entries are lost and no beat is emitted.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined:
  - Two entries (main + skid).
  - ready_o is registered as above.
  - occ_o ranges 0..2.
- Undefined:
  - Single entry.
  - ready_o = (!valid_o | ready_i) & !stall_i & !flush_i & !rst_i, a combinational path from ready_i.
  - occ_o ranges 0..1 (bit 1 tied to 0).
  - All other behaviour is identical.

## Test plan
- Reset: hold rst_i for 2 cycles with valid_i=1 and data_i all 1s -> valid_o=0, data_o=0, ctrl_o=0, occ_o=0, ready_o=0. After release -> ready_o=1.
- Streaming: 8 beats with data lane0 = 1..8, ready_i=1 -> lane0 = 1..8 on consecutive cycles, first beat 1 cycle after the first accept.
- Back-pressure (SKID_EN): ready_i=0 after beat 1 while beats 2 and 3 are offered -> beat 2 goes to skid, occ_o=2, ready_o=0, beat 3 held upstream. After ready_i=1 -> output order 1, 2, 3 with no loss or duplication.
- Stall: stall_i=1 for 3 cycles with valid_o=1, ctrl=7'h7F and ready_i=1 -> outputs frozen, no transfer, ready_o=0. Streaming resumes on the next edge after stall_i falls.
- Flush plus input: flush_i=1 with occ_o=2 and valid_i=1 -> next cycle valid_o=0, ctrl_o=0, occ_o=0; the offered beat never appears.
- Priority: rst_i=1 together with flush_i=1 and stall_i=1 -> reset values. stall_i=1 together with flush_i=1 -> flush wins and valid_o=0.
